bcd_to_bin_3d: RTL and testbench

Sequential three-digit BCD to binary converter, the inverse of the score/number binary-to-BCD path. It accepts hundreds/tens/ones BCD digits on a start pulse and produces a 10-bit binary value (0..999) using iterative reverse double-dabble (shift right, subtract 3). Typical users are digit-entry or stored-BCD logic, such as score or level values kept as decimal digits, that must feed arithmetic or comparison logic in binary.

---
 rtl/bcd_to_bin_3d.sv | 173 +++++++++++++++++
 tb/tb_bcd_to_bin_3d.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_3d.sv
// bcd_to_bin_3d: sequential three-digit BCD to 10-bit binary converter.
// Reverse double-dabble: ten right shifts of {bcd, work}, each followed by a
// per-nibble "subtract 3 if >= 8" correction on the BCD register.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 conversion request, accepted when not busy
//   hundreds/tens/ones    BCD digits captured at accept
//   binary                last converted value (held)
//   done                  one-cycle pulse when binary/err are updated
//   busy                  high while shifting
//   err                   last accepted input had a digit > 9 (held)
module bcd_to_bin_3d (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [9:0] binary,
    output logic       done,
    output logic       busy,
    output logic       err
);

    localparam int unsigned DIG_W  = 4;
    localparam int unsigned NDIG   = 3;
    localparam int unsigned BCD_W  = DIG_W * NDIG;
    localparam int unsigned BIN_W  = 10;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);
    localparam logic [DIG_W-1:0] MAX_DIG   = DIG_W'(9);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;
    logic               pend_q, pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               digit_bad_c;
    logic               accept_c;
    logic [BCD_W-1:0]   bcd_sh_c;
    logic [BCD_W-1:0]   bcd_fix_c;
    logic [BIN_W-1:0]   work_sh_c;

    function automatic logic [DIG_W-1:0] fix_nib(input logic [DIG_W-1:0] nib);
        return (nib >= DIG_W'(8)) ? nib - DIG_W'(3) : nib;
    endfunction

    // Request qualification; an invalid request spends one pending cycle in
    // IDLE so its done pulse lands one cycle after accept.
    assign digit_bad_c = (hundreds > MAX_DIG) || (tens > MAX_DIG) || (ones > MAX_DIG);
    assign accept_c    = start && (((state_q == IDLE) && !pend_q) || (state_q == DONE));

    // One reverse double-dabble step.
    always_comb begin
        work_sh_c = {bcd_q[0], work_q[BIN_W-1:1]};
        bcd_sh_c  = {1'b0, bcd_q[BCD_W-1:1]};
        bcd_fix_c = bcd_sh_c;
        for (int i = 0; i < NDIG; i++) begin
            bcd_fix_c[i*DIG_W +: DIG_W] = fix_nib(bcd_sh_c[i*DIG_W +: DIG_W]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = DONE;
                end else if (accept_c && !digit_bad_c) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (accept_c && !digit_bad_c) begin
                    state_d = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs, decoded from the next state so they leave flops.
    always_comb begin
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // Datapath next values.
    always_comb begin
        bcd_d  = bcd_q;
        work_d = work_q;
        cnt_d  = cnt_q;
        bin_d  = bin_q;
        err_d  = err_q;
        pend_d = 1'b0;
        if (accept_c) begin
            if (digit_bad_c) begin
                pend_d = 1'b1;
            end else begin
                bcd_d  = {hundreds, tens, ones};
                work_d = '0;
                cnt_d  = '0;
            end
        end else if (pend_q) begin
            bin_d = '0;
            err_d = 1'b1;
        end else if (state_q == SHIFT) begin
            bcd_d  = bcd_fix_c;
            work_d = work_sh_c;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
                bin_d = work_sh_c;
                err_d = 1'b0;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_q  <= '0;
            work_q <= '0;
            cnt_q  <= '0;
            bin_q  <= '0;
            err_q  <= 1'b0;
            pend_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            work_q <= work_d;
            cnt_q  <= cnt_d;
            bin_q  <= bin_d;
            err_q  <= err_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign binary = bin_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bcd_to_bin_3d.sv
// Self-checking bench for bcd_to_bin_3d against an arithmetic reference.
module tb_bcd_to_bin_3d;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] hundreds, tens, ones;
    logic [9:0] binary;
    logic       done, busy, err;

    int total    = 0;
    int passed   = 0;
    int last_bin = 0;
    int last_err = 0;

    always #5 clk = ~clk;

    bcd_to_bin_3d dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .binary   (binary),
        .done     (done),
        .busy     (busy),
        .err      (err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end else begin
            passed++;
        end
    endtask

    function automatic bit ref_bad(input int h, input int t, input int o);
        return (h > 9) || (t > 9) || (o > 9);
    endfunction

    function automatic int ref_val(input int h, input int t, input int o);
        return ref_bad(h, t, o) ? 0 : 100 * h + 10 * t + o;
    endfunction

    // Present a request; it is sampled on the next rising edge.
    task automatic launch(input int h, input int t, input int o, input bit hold);
        @(negedge clk);
        start    = 1'b1;
        hundreds = 4'(h);
        tens     = 4'(t);
        ones     = 4'(o);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Called one step after the accept edge; follows the conversion to done.
    task automatic wait_done(input string tag, input int h, input int t, input int o,
                             input bit hold, input int poke_a, input int poke_b);
        bit bad;
        int exp_bin, exp_lat, cyc;
        bad     = ref_bad(h, t, o);
        exp_bin = ref_val(h, t, o);
        exp_lat = bad ? 1 : 10;
        cyc     = 0;
        while (!done && cyc < 20) begin
            chk({tag, "_busy"}, int'(busy), bad ? 0 : 1);
            chk({tag, "_held_bin"}, int'(binary), last_bin);
            chk({tag, "_held_err"}, int'(err), last_err);
            if (!hold) begin
                if (cyc == poke_a || cyc == poke_b) begin
                    start = 1'b1; hundreds = 4'd7; tens = 4'd8; ones = 4'd9;
                end else begin
                    start = 1'b0;
                    hundreds = 4'($urandom); tens = 4'($urandom); ones = 4'($urandom);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!hold) start = 1'b0;
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_bin"}, int'(binary), exp_bin);
        chk({tag, "_err"}, int'(err), bad ? 1 : 0);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        last_bin = exp_bin;
        last_err = bad ? 1 : 0;
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, int'(done), 0);
    endtask

    task automatic convert(input string tag, input int h, input int t, input int o);
        launch(h, t, o, 1'b0);
        wait_done(tag, h, t, o, 1'b0, -1, -1);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        hundreds = '0;
        tens     = '0;
        ones     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bin", int'(binary), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        reset_n = 1'b1;

        convert("max999", 9, 9, 9);
        convert("seq0", 0, 0, 0);
        convert("seq511", 5, 1, 1);
        convert("seq256", 2, 5, 6);
        convert("seq100", 1, 0, 0);
        convert("seq9", 0, 0, 9);

        convert("bad", 3, 10, 2);
        convert("after_bad", 1, 2, 3);

        // Pulses during busy cycles 3 and 9 must be ignored.
        launch(4, 5, 6, 1'b0);
        wait_done("ignore", 4, 5, 6, 1'b0, 3, 9);

        // Start held high: a result every 11 cycles.
        launch(0, 4, 2, 1'b1);
        for (int k = 0; k < 3; k++) wait_done("held", 0, 4, 2, 1'b1, -1, -1);
        start = 1'b0;
        wait_done("held_last", 0, 4, 2, 1'b0, -1, -1);

        // Reset in the middle of a conversion.
        convert("pre_rst", 9, 9, 9);
        launch(1, 1, 1, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_bin", int'(binary), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_err", int'(err), 0);
        last_bin = 0;
        last_err = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_done", int'(done), 0);
        end
        convert("after_rst", 0, 1, 7);

        // Exhaustive valid sweep.
        for (int h = 0; h < 10; h++)
            for (int t = 0; t < 10; t++)
                for (int o = 0; o < 10; o++)
                    convert("sweep", h, t, o);

        // Random digits, occasionally invalid.
        for (int k = 0; k < 200; k++) begin
            convert("rand", int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                    int'($urandom_range(0, 11)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
